// File: rtl/bip_pkg.sv
// Shared definitions for the BIP accumulator processor control path:
// widths, opcodes, muxA encodings, sequencer states and the decoder bundle.
package bip_pkg;

  localparam int unsigned NB_PC_DEF        = 11;
  localparam int unsigned NB_OPCODE        = 5;
  localparam int unsigned NB_OPERANDO      = 11;
  localparam int unsigned NB_INSTR         = NB_OPCODE + NB_OPERANDO;
  localparam int unsigned NB_DECODER_SEL_A = 2;
  localparam int unsigned NB_CNT           = 32;

  localparam logic [NB_OPCODE-1:0] OP_HLT  = 5'b00000;
  localparam logic [NB_OPCODE-1:0] OP_STO  = 5'b00001;
  localparam logic [NB_OPCODE-1:0] OP_LD   = 5'b00010;
  localparam logic [NB_OPCODE-1:0] OP_LDI  = 5'b00011;
  localparam logic [NB_OPCODE-1:0] OP_ADD  = 5'b00100;
  localparam logic [NB_OPCODE-1:0] OP_ADDI = 5'b00101;
  localparam logic [NB_OPCODE-1:0] OP_SUB  = 5'b00110;
  localparam logic [NB_OPCODE-1:0] OP_SUBI = 5'b00111;

  localparam logic [NB_DECODER_SEL_A-1:0] SELA_DMEM = 2'b00;
  localparam logic [NB_DECODER_SEL_A-1:0] SELA_IMM  = 2'b01;
  localparam logic [NB_DECODER_SEL_A-1:0] SELA_ALU  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  typedef struct packed {
    logic [NB_DECODER_SEL_A-1:0] sel_a;
    logic                        sel_b;
    logic                        wr_acc;
    logic [NB_OPCODE-1:0]        op;
    logic                        dm_rd;
    logic                        dm_wr;
    logic                        is_halt;
  } dec_ctrl_t;

endpackage

// File: rtl/bip_control_if.sv
// Bundle between the sequencer and its program memory, data memory,
// accumulator datapath and top-level status.
interface bip_control_if #(
  parameter int unsigned NB_PC = bip_pkg::NB_PC_DEF
);
  import bip_pkg::*;

  logic [NB_INSTR-1:0]         i_pm_data;
  logic [NB_PC-1:0]            o_pm_addr;
  logic                        o_pm_rd;
  logic [NB_OPERANDO-1:0]      o_dm_addr;
  logic                        o_dm_rd;
  logic                        o_dm_wr;
  logic [NB_DECODER_SEL_A-1:0] o_selA;
  logic                        o_selB;
  logic                        o_wrAcc;
  logic [NB_OPCODE-1:0]        o_op;
  logic [NB_OPERANDO-1:0]      o_operando;
  logic                        o_busy;
  logic                        o_halt;
  logic [NB_CNT-1:0]           o_cycle_cnt;

  modport master (
    input  i_pm_data,
    output o_pm_addr, o_pm_rd, o_dm_addr, o_dm_rd, o_dm_wr,
    output o_selA, o_selB, o_wrAcc, o_op, o_operando,
    output o_busy, o_halt, o_cycle_cnt
  );

  modport slave (
    output i_pm_data,
    input  o_pm_addr, o_pm_rd, o_dm_addr, o_dm_rd, o_dm_wr,
    input  o_selA, o_selB, o_wrAcc, o_op, o_operando,
    input  o_busy, o_halt, o_cycle_cnt
  );

endinterface

// File: rtl/bip_decoder.sv
// Opcode to datapath/data-memory control map; unlisted opcodes decode as NOP.
module bip_decoder
  import bip_pkg::*;
(
  input  logic [NB_OPCODE-1:0] opcode,
  output dec_ctrl_t            ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_HLT:  ctrl.is_halt = 1'b1;
      OP_STO:  ctrl.dm_wr   = 1'b1;
      OP_LD: begin
        ctrl.sel_a  = SELA_DMEM;
        ctrl.wr_acc = 1'b1;
        ctrl.dm_rd  = 1'b1;
      end
      OP_LDI: begin
        ctrl.sel_a  = SELA_IMM;
        ctrl.wr_acc = 1'b1;
      end
      OP_ADD, OP_SUB: begin
        ctrl.sel_a  = SELA_ALU;
        ctrl.sel_b  = 1'b0;
        ctrl.op     = opcode;
        ctrl.wr_acc = 1'b1;
        ctrl.dm_rd  = 1'b1;
      end
      OP_ADDI, OP_SUBI: begin
        ctrl.sel_a  = SELA_ALU;
        ctrl.sel_b  = 1'b1;
        ctrl.op     = opcode;
        ctrl.wr_acc = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/bip_control.sv
// BIP instruction sequencer: FETCH/DECODE/EXEC loop over program memory,
// driving accumulator datapath selects and data-memory strobes.
module bip_control
  import bip_pkg::*;
#(
  parameter int unsigned NB_PC = NB_PC_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  bip_control_if.master bus
);

  state_t               state, state_nxt;
  logic [NB_PC-1:0]     pc, pc_nxt;
  logic [NB_INSTR-1:0]  ir, ir_nxt;
  logic [NB_CNT-1:0]    cnt, cnt_nxt;
  logic [NB_OPCODE-1:0] dec_opcode;
  logic                 busy_c;
  dec_ctrl_t            dec;

  // DECODE looks ahead at the fetched word so the data-memory read can
  // be issued one cycle before EXEC; EXEC decodes from IR.
  assign dec_opcode = (state == ST_DECODE) ? bus.i_pm_data[NB_INSTR-1 -: NB_OPCODE]
                                           : ir[NB_INSTR-1 -: NB_OPCODE];

  bip_decoder u_decoder (
    .opcode (dec_opcode),
    .ctrl   (dec)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
      pc    <= '0;
      ir    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    ir_nxt        = ir;
    cnt_nxt       = cnt;
    busy_c        = 1'b0;
    bus.o_pm_rd   = 1'b0;
    bus.o_dm_addr = '0;
    bus.o_dm_rd   = 1'b0;
    bus.o_dm_wr   = 1'b0;
    bus.o_selA    = SELA_DMEM;
    bus.o_selB    = 1'b0;
    bus.o_wrAcc   = 1'b0;
    bus.o_op      = '0;

    case (state)
      ST_IDLE, ST_HALT: begin
        if (i_start) begin
          state_nxt = ST_FETCH;
          pc_nxt    = '0;
          cnt_nxt   = '0;
        end
      end
      ST_FETCH: begin
        busy_c      = 1'b1;
        bus.o_pm_rd = 1'b1;
        state_nxt   = ST_DECODE;
      end
      ST_DECODE: begin
        busy_c      = 1'b1;
        ir_nxt      = bus.i_pm_data;
        pc_nxt      = pc + NB_PC'(1);
        bus.o_dm_rd = dec.dm_rd;
        if (dec.dm_rd) bus.o_dm_addr = bus.i_pm_data[NB_OPERANDO-1:0];
        state_nxt   = dec.is_halt ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        busy_c      = 1'b1;
        bus.o_selA  = dec.sel_a;
        bus.o_selB  = dec.sel_b;
        bus.o_wrAcc = dec.wr_acc;
        bus.o_op    = dec.op;
        bus.o_dm_wr = dec.dm_wr;
        if (dec.dm_wr) bus.o_dm_addr = ir[NB_OPERANDO-1:0];
        state_nxt   = ST_FETCH;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Saturating count of busy cycles
    if (busy_c && !(&cnt)) cnt_nxt = cnt + NB_CNT'(1);
  end

  assign bus.o_busy      = busy_c;
  assign bus.o_halt      = (state == ST_HALT);
  assign bus.o_pm_addr   = pc;
  assign bus.o_operando  = ir[NB_OPERANDO-1:0];
  assign bus.o_cycle_cnt = cnt;

endmodule
